alu_operand_issue: RTL and testbench
====================================

Name: alu_operand_issue

Overview:
ID/EX issue stage that drives the 64-bit ALU's a, b and 4-bit ALUOp inputs, one instruction per cycle. Registers decoded operands from the decode stage and translates the 2-bit main-control ALUOp plus funct3/funct7[5] into the 4-bit ALU operation code. Applies EX/MEM and MEM/WB forwarding on the registered operands. Supports stall (hold) and flush (bubble).

Parameters:
XLEN, 64, operand/result width
REGW, 5, register index width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  decode stage presents an instruction
stall  input  1  hold stage contents
flush  input  1  replace stage contents with bubble
ALUOpMain  input  2  main control: 00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
ReadData1  input  XLEN  register file rs1 data
ReadData2  input  XLEN  register file rs2 data
Imm  input  XLEN  sign-extended immediate
ALUSrc  input  1  1: b = immediate
rs1, rs2, rd  input  REGW  register indices
RegWriteIn  input  1  instruction writes rd
ExMemRegWrite  input  1  EX/MEM stage writes
ExMemRd  input  REGW  EX/MEM destination
ExMemResult  input  XLEN  EX/MEM ALU result
MemWbRegWrite  input  1  MEM/WB stage writes
MemWbRd  input  REGW  MEM/WB destination
MemWbData  input  XLEN  MEM/WB writeback data
a  output  XLEN  ALU operand a
b  output  XLEN  ALU operand b
ALUOp  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
StoreData  output  XLEN  forwarded rs2 value
RdOut  output  REGW  registered rd
RegWriteOut  output  1  registered write enable
OutValid  output  1  stage holds a valid instruction
Illegal  output  1  registered decode was unsupported

Behaviour:
- One clock domain. All state updates on rising clk. Priority per edge: reset_n=0 > flush > stall > capture.
- Reset, flush and capture with in_valid=0 clear OutValid, RegWriteOut, Illegal, ALUOp (to 0000), rd, rs1/rs2 indices, and operand/immediate registers, all to 0. Because rs1 = rs2 = 0 is never forwarded, a = b = StoreData = 0 after reset.
- stall=1 (no flush): every register holds its value. Outputs remain stable apart from forwarding effects.
- Capture (in_valid=1): register ReadData1, ReadData2, Imm, ALUSrc, rs1, rs2, rd and the decoded ALUOp. Set OutValid=1. RegWriteOut = RegWriteIn & ~illegal. Latency is one cycle from decode inputs to a/b/ALUOp.
- Decode:
  - ALUOpMain 00 -> 0010; 01 -> 0110.
  - 10 (R-type): funct3 000 with f7_5=0 -> 0010; 000 with f7_5=1 -> 0110; 111 -> 0000; 110 -> 0001; 100 with f7_5=1 -> 1100.
  - 11 (I-type): 000 -> 0010; 111 -> 0000; 110 -> 0001.
  - Any other combination -> ALUOp 0010, Illegal=1, RegWriteOut=0, OutValid=1.
- Forwarding is combinational on the registered indices:
  - srcA = ExMemResult if ExMemRegWrite and ExMemRd!=0 and ExMemRd==rs1_q.
  - Otherwise MemWbData if MemWbRegWrite and MemWbRd!=0 and MemWbRd==rs1_q.
  - Otherwise the registered ReadData1. EX/MEM wins when both stages match.
  - srcB uses the same rule with rs2_q.
  - a = srcA. b = Imm_q if ALUSrc_q, else srcB. StoreData = srcB always.
- The forwarding inputs are live during a stall, so a/b may change while the registers hold.
- Outputs do not depend on OutValid: a bubble presents zeros and ALUOp 0000.
- Width: all data paths are XLEN bits; no extension or truncation occurs in this block.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 and arbitrary inputs -> OutValid=0, RegWriteOut=0, a=b=0, ALUOp=0000, Illegal=0.
- Decode sweep: R-type f3=000 f7_5=1, then f3=100 f7_5=1, then I-type f3=110, each with in_valid=1 -> ALUOp 0110, then 1100, then 0001 on consecutive cycles. R-type f3=010 -> ALUOp 0010, Illegal=1, RegWriteOut=0.
- Forward priority: issue rs1=5, ReadData1=0x11, ExMemRd=5 with ExMemResult=0xAA, MemWbRd=5 with MemWbData=0xBB (both writing) -> a=0xAA. Drop ExMemRegWrite -> a=0xBB. Set rs1=0 with ExMemRd=0 -> a=ReadData1.
- Immediate path: ALUSrc=1, Imm=0xFFFF_FFFF_FFFF_FFF0, rs2=3 matching ExMemRd=3 -> b=0xFFFF_FFFF_FFFF_FFF0, StoreData=ExMemResult.
- Stall then flush: capture ADD rd=7; assert stall for 3 cycles while changing inputs -> RdOut=7 and ALUOp=0010 held. Assert stall and flush together -> next cycle OutValid=0, RegWriteOut=0.
- Reset mid-stream: drive valid instructions every cycle, pulse reset_n=0 for one edge together with stall=1 -> registers cleared that edge. The first capture after reset_n returns high appears one cycle later.

Source files
------------

// File: rtl/alu_operand_issue_if.sv
// Issue-stage bus: decode-side instruction fields, EX/MEM and MEM/WB forwarding taps,
// and the registered ALU operand outputs.
interface alu_operand_issue_if #(
    parameter int XLEN = 64,
    parameter int REGW = 5
);
    logic            in_valid;
    logic            stall;
    logic            flush;
    logic [1:0]      ALUOpMain;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic [XLEN-1:0] Imm;
    logic            ALUSrc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic            RegWriteIn;
    logic            ExMemRegWrite;
    logic [REGW-1:0] ExMemRd;
    logic [XLEN-1:0] ExMemResult;
    logic            MemWbRegWrite;
    logic [REGW-1:0] MemWbRd;
    logic [XLEN-1:0] MemWbData;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ALUOp;
    logic [XLEN-1:0] StoreData;
    logic [REGW-1:0] RdOut;
    logic            RegWriteOut;
    logic            OutValid;
    logic            Illegal;

    modport master (
        output in_valid, stall, flush, ALUOpMain, funct3, funct7_5,
               ReadData1, ReadData2, Imm, ALUSrc, rs1, rs2, rd, RegWriteIn,
               ExMemRegWrite, ExMemRd, ExMemResult,
               MemWbRegWrite, MemWbRd, MemWbData,
        input  a, b, ALUOp, StoreData, RdOut, RegWriteOut, OutValid, Illegal
    );

    modport slave (
        input  in_valid, stall, flush, ALUOpMain, funct3, funct7_5,
               ReadData1, ReadData2, Imm, ALUSrc, rs1, rs2, rd, RegWriteIn,
               ExMemRegWrite, ExMemRd, ExMemResult,
               MemWbRegWrite, MemWbRd, MemWbData,
        output a, b, ALUOp, StoreData, RdOut, RegWriteOut, OutValid, Illegal
    );
endinterface

// File: rtl/alu_operand_issue.sv
// ID/EX issue stage: registers decoded operands, translates main-control ALUOp into the
// 4-bit ALU code, and forwards EX/MEM and MEM/WB results onto the registered operands.
module alu_operand_issue #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_operand_issue_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [3:0]      dec_op;
    logic            dec_illegal;

    logic            valid_q;
    logic            regwrite_q;
    logic            illegal_q;
    logic [3:0]      aluop_q;
    logic [REGW-1:0] rd_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [XLEN-1:0] rdata1_q;
    logic [XLEN-1:0] rdata2_q;
    logic [XLEN-1:0] imm_q;
    logic            alusrc_q;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            clear_stage;
    logic            capture;

    // Unsupported encodings still issue as ADD so the ALU sees a defined op.
    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (bus.ALUOpMain)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000: dec_op = bus.funct7_5 ? OP_SUB : OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b100: begin
                        if (bus.funct7_5) dec_op = OP_NOR;
                        else              dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (bus.funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign clear_stage = !reset_n || bus.flush || (!bus.stall && !bus.in_valid);
    assign capture     = !bus.stall && bus.in_valid;

    always_ff @(posedge clk) begin
        if (clear_stage) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            aluop_q    <= OP_AND;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
        end else if (capture) begin
            valid_q    <= 1'b1;
            regwrite_q <= bus.RegWriteIn && !dec_illegal;
            illegal_q  <= dec_illegal;
            aluop_q    <= dec_op;
            rd_q       <= bus.rd;
            rs1_q      <= bus.rs1;
            rs2_q      <= bus.rs2;
            rdata1_q   <= bus.ReadData1;
            rdata2_q   <= bus.ReadData2;
            imm_q      <= bus.Imm;
            alusrc_q   <= bus.ALUSrc;
        end
    end

    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        src_a = rdata1_q;
        if (bus.ExMemRegWrite && (bus.ExMemRd != '0) && (bus.ExMemRd == rs1_q))
            src_a = bus.ExMemResult;
        else if (bus.MemWbRegWrite && (bus.MemWbRd != '0) && (bus.MemWbRd == rs1_q))
            src_a = bus.MemWbData;
    end

    always_comb begin
        src_b = rdata2_q;
        if (bus.ExMemRegWrite && (bus.ExMemRd != '0) && (bus.ExMemRd == rs2_q))
            src_b = bus.ExMemResult;
        else if (bus.MemWbRegWrite && (bus.MemWbRd != '0) && (bus.MemWbRd == rs2_q))
            src_b = bus.MemWbData;
    end

    assign bus.a           = src_a;
    assign bus.b           = alusrc_q ? imm_q : src_b;
    assign bus.StoreData   = src_b;
    assign bus.ALUOp       = aluop_q;
    assign bus.RdOut       = rd_q;
    assign bus.RegWriteOut = regwrite_q;
    assign bus.OutValid    = valid_q;
    assign bus.Illegal     = illegal_q;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: decode table, directed forwarding/stall/reset
// sequences, then randomized traffic against a behavioural model of the stage.
module tb_alu_operand_issue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_operand_issue_if bus ();
    alu_operand_issue dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] main;
        logic [2:0] f3;
        logic       f75;
        logic       rwin;
        logic [3:0] op;
        logic       ill;
        logic       rwout;
    } vec_t;

    vec_t vecs[14];

    // Legal decodes keyed by {ALUOpMain, funct3, funct7_5}; absent keys are illegal.
    logic [3:0] op_tab [logic [5:0]];

    logic        m_valid, m_rw, m_ill, m_src;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [63:0] m_r1, m_r2, m_imm;

    task automatic build_tab();
        for (int f3 = 0; f3 < 8; f3++) begin
            for (int f7 = 0; f7 < 2; f7++) begin
                op_tab[{2'b00, f3[2:0], f7[0]}] = 4'b0010;
                op_tab[{2'b01, f3[2:0], f7[0]}] = 4'b0110;
            end
        end
        op_tab[{2'b10, 3'b000, 1'b0}] = 4'b0010;
        op_tab[{2'b10, 3'b000, 1'b1}] = 4'b0110;
        op_tab[{2'b10, 3'b100, 1'b1}] = 4'b1100;
        for (int f7 = 0; f7 < 2; f7++) begin
            op_tab[{2'b10, 3'b111, f7[0]}] = 4'b0000;
            op_tab[{2'b10, 3'b110, f7[0]}] = 4'b0001;
            op_tab[{2'b11, 3'b000, f7[0]}] = 4'b0010;
            op_tab[{2'b11, 3'b111, f7[0]}] = 4'b0000;
            op_tab[{2'b11, 3'b110, f7[0]}] = 4'b0001;
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_ill = 0; m_src = 0; m_op = 0;
        m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
    endtask

    task automatic model_edge();
        logic [5:0] key;
        key = {bus.ALUOpMain, bus.funct3, bus.funct7_5};
        if (!reset_n || bus.flush) model_clear();
        else if (bus.stall) ;
        else if (!bus.in_valid) model_clear();
        else begin
            m_valid = 1;
            m_ill   = !op_tab.exists(key);
            m_op    = m_ill ? 4'b0010 : op_tab[key];
            m_rw    = bus.RegWriteIn && !m_ill;
            m_rd = bus.rd; m_rs1 = bus.rs1; m_rs2 = bus.rs2;
            m_r1 = bus.ReadData1; m_r2 = bus.ReadData2; m_imm = bus.Imm; m_src = bus.ALUSrc;
        end
    endtask

    function automatic logic [63:0] fwd_exp(input logic [4:0] idx, input logic [63:0] regv);
        if (idx != 0 && bus.ExMemRegWrite && bus.ExMemRd == idx) return bus.ExMemResult;
        if (idx != 0 && bus.MemWbRegWrite && bus.MemWbRd == idx) return bus.MemWbData;
        return regv;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] sb;
        sb = fwd_exp(m_rs2, m_r2);
        check({tag, ".OutValid"},    64'(bus.OutValid),    64'(m_valid));
        check({tag, ".RegWriteOut"}, 64'(bus.RegWriteOut), 64'(m_rw));
        check({tag, ".Illegal"},     64'(bus.Illegal),     64'(m_ill));
        check({tag, ".ALUOp"},       64'(bus.ALUOp),       64'(m_op));
        check({tag, ".RdOut"},       64'(bus.RdOut),       64'(m_rd));
        check({tag, ".a"},           bus.a,                fwd_exp(m_rs1, m_r1));
        check({tag, ".b"},           bus.b,                m_src ? m_imm : sb);
        check({tag, ".StoreData"},   bus.StoreData,        sb);
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_inputs();
        bus.ALUOpMain = 2'($urandom_range(0, 3));
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.funct7_5 = 1'($urandom_range(0, 1));
        bus.ReadData1 = rnd64(); bus.ReadData2 = rnd64(); bus.Imm = rnd64();
        bus.ALUSrc = 1'($urandom_range(0, 1));
        bus.rs1 = 5'($urandom_range(0, 7)); bus.rs2 = 5'($urandom_range(0, 7));
        bus.rd = 5'($urandom_range(0, 31));
        bus.RegWriteIn = 1'($urandom_range(0, 1));
        bus.ExMemRegWrite = 1'($urandom_range(0, 1));
        bus.ExMemRd = 5'($urandom_range(0, 7)); bus.ExMemResult = rnd64();
        bus.MemWbRegWrite = 1'($urandom_range(0, 1));
        bus.MemWbRd = 5'($urandom_range(0, 7)); bus.MemWbData = rnd64();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1};
        vecs[1]  = '{2'b10, 3'b100, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 3'b110, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[3]  = '{2'b10, 3'b010, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 3'b000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 3'b110, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1};
        vecs[7]  = '{2'b11, 3'b000, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[8]  = '{2'b11, 3'b111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{2'b00, 3'b101, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[10] = '{2'b01, 3'b011, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 3'b100, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 3'b001, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[13] = '{2'b10, 3'b101, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0};
        build_tab();
        model_clear();

        // reset held two cycles with live valid traffic
        rand_inputs();
        bus.in_valid = 1; bus.stall = 0; bus.flush = 0;
        reset_n = 0;
        clk_step();
        rand_inputs();
        clk_step();
        check("rst.OutValid", 64'(bus.OutValid), 64'd0);
        check("rst.RegWriteOut", 64'(bus.RegWriteOut), 64'd0);
        check("rst.Illegal", 64'(bus.Illegal), 64'd0);
        check("rst.ALUOp", 64'(bus.ALUOp), 64'd0);
        check("rst.a", bus.a, 64'd0);
        check("rst.b", bus.b, 64'd0);
        check("rst.StoreData", bus.StoreData, 64'd0);
        reset_n = 1;

        for (int i = 0; i < 14; i++) begin
            rand_inputs();
            bus.in_valid = 1; bus.stall = 0; bus.flush = 0;
            bus.ALUOpMain = vecs[i].main; bus.funct3 = vecs[i].f3;
            bus.funct7_5 = vecs[i].f75; bus.RegWriteIn = vecs[i].rwin;
            clk_step();
            check($sformatf("vec%0d.ALUOp", i), 64'(bus.ALUOp), 64'(vecs[i].op));
            check($sformatf("vec%0d.Illegal", i), 64'(bus.Illegal), 64'(vecs[i].ill));
            check($sformatf("vec%0d.RegWriteOut", i), 64'(bus.RegWriteOut), 64'(vecs[i].rwout));
            check($sformatf("vec%0d.OutValid", i), 64'(bus.OutValid), 64'd1);
            check_model($sformatf("vec%0d", i));
        end

        // forwarding priority
        rand_inputs();
        bus.ALUOpMain = 2'b10; bus.funct3 = 3'b000; bus.funct7_5 = 0;
        bus.rs1 = 5; bus.ReadData1 = 64'h11;
        bus.ExMemRegWrite = 1; bus.ExMemRd = 5; bus.ExMemResult = 64'hAA;
        bus.MemWbRegWrite = 1; bus.MemWbRd = 5; bus.MemWbData = 64'hBB;
        clk_step();
        check("fwd.exmem", bus.a, 64'hAA);
        bus.ExMemRegWrite = 0;
        #1;
        check("fwd.memwb", bus.a, 64'hBB);
        bus.ExMemRegWrite = 1; bus.ExMemRd = 0; bus.rs1 = 0;
        clk_step();
        check("fwd.x0", bus.a, 64'h11);
        check_model("fwd");

        // immediate path with rs2 forwarded onto StoreData
        rand_inputs();
        bus.ALUSrc = 1; bus.Imm = 64'hFFFF_FFFF_FFFF_FFF0; bus.rs2 = 3; bus.ReadData2 = 64'h99;
        bus.ExMemRegWrite = 1; bus.ExMemRd = 3; bus.ExMemResult = 64'h1234_5678;
        clk_step();
        check("imm.b", bus.b, 64'hFFFF_FFFF_FFFF_FFF0);
        check("imm.StoreData", bus.StoreData, 64'h1234_5678);

        // stall holds, then stall+flush bubbles
        rand_inputs();
        bus.ALUOpMain = 2'b00; bus.rd = 7; bus.RegWriteIn = 1;
        clk_step();
        check("stall.cap.RdOut", 64'(bus.RdOut), 64'd7);
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.ALUOpMain = 2'b10; bus.funct3 = 3'b111; bus.rd = 5'(12 + i);
            bus.stall = 1;
            clk_step();
            check($sformatf("stall%0d.RdOut", i), 64'(bus.RdOut), 64'd7);
            check($sformatf("stall%0d.ALUOp", i), 64'(bus.ALUOp), 64'b0010);
            check_model($sformatf("stall%0d", i));
        end
        bus.flush = 1;
        clk_step();
        check("flush.OutValid", 64'(bus.OutValid), 64'd0);
        check("flush.RegWriteOut", 64'(bus.RegWriteOut), 64'd0);
        check_model("flush");

        // reset pulse mid-stream wins over stall
        bus.stall = 0; bus.flush = 0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            clk_step();
            check_model($sformatf("pre_rst%0d", i));
        end
        rand_inputs();
        reset_n = 0; bus.stall = 1;
        clk_step();
        check("midrst.OutValid", 64'(bus.OutValid), 64'd0);
        check("midrst.RdOut", 64'(bus.RdOut), 64'd0);
        check("midrst.ALUOp", 64'(bus.ALUOp), 64'd0);
        reset_n = 1; bus.stall = 0;
        rand_inputs();
        bus.rd = 9;
        clk_step();
        check("postrst.OutValid", 64'(bus.OutValid), 64'd1);
        check("postrst.RdOut", 64'(bus.RdOut), 64'd9);
        check_model("postrst");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            bus.in_valid = ($urandom_range(0, 4) != 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 29) != 0);
            clk_step();
            check_model($sformatf("rnd%0d", i));
            bus.ExMemRd = 5'($urandom_range(0, 7));
            bus.MemWbRd = 5'($urandom_range(0, 7));
            bus.ExMemRegWrite = 1'($urandom_range(0, 1));
            #1;
            check_model($sformatf("rnd%0d.live", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
